load_mem_unit: RTL and testbench
================================

Name: load_mem_unit

Overview:
- Memory-access stage placed directly downstream of the load decoder.
- Accepts a decoded load: rd, imm, load_control, plus the rs1 register value from the register file.
- Computes the effective address, runs a request/grant/response handshake with data memory, then aligns and extends the returned word.
- Presents the result to the writeback stage, or raises a misalignment or bus-timeout error instead.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles to wait in WAIT for mem_rvalid before declaring a bus error (range 1..255).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ld_valid  input  1  a decoded load is offered.
- ld_ready  output  1  unit can accept a load; high only in IDLE.
- rs1_data  input  32  base register value.
- imm  input  12  signed offset.
- rd  input  5  destination register.
- load_control  input  3  `LB/`LH/`LW/`LBU/`LHU/`LD_NOP, from the processor defines.
- flush  input  1  kill the in-flight load.
- mem_req  output  1  memory read request.
- mem_addr  output  32  word-aligned address, bits[1:0]=0.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read data.
- wb_valid  output  1  one-cycle pulse, result valid.
- wb_rd  output  5  destination register for the result.
- wb_data  output  32  extended load result.
- ld_err  output  1  one-cycle error pulse.
- ld_err_cause  output  2  0 = none, 1 = misaligned, 2 = bus timeout.
- ld_err_addr  output  32  faulting effective address.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - ld_ready=1; every other output is 0.
  - Address, rd, control and timeout registers clear to 0.
- Effective address: ea = rs1_data + sign_extend(imm) in 32 bits; carry-out is discarded (wraps).
- Accept: when ld_valid && ld_ready in IDLE, ea, rd and load_control are registered that cycle.
  - `LD_NOP: state returns to IDLE, no memory access, no wb_valid, no error.
  - Misaligned (LH/LHU with ea[0]=1, or LW with ea[1:0]!=0): next cycle ld_err=1, cause=1, ld_err_addr=ea. No request is issued. State returns to IDLE.
  - Otherwise the next state is REQ.
- REQ:
  - mem_req=1 and mem_addr={ea[31:2],2'b00}, both held stable until mem_gnt.
  - If mem_gnt=1, the next state is WAIT and mem_req drops the following cycle.
- WAIT:
  - The timeout counter increments each cycle starting from 0.
  - On mem_rvalid, mem_rdata is captured and the next state is WB.
  - If the counter reaches TIMEOUT_CYCLES with no mem_rvalid: ld_err pulse with cause=2, then IDLE.
- WB:
  - wb_valid=1 for exactly one cycle, with wb_rd=rd and wb_data=extracted value; then IDLE.
  - rd=0 is still written back; the register file ignores x0.
- Extraction from the captured word:
  - byte = word[8*ea[1:0] +: 8]
  - half = word[16*ea[1] +: 16]
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Minimum latency (grant in the REQ cycle, rvalid one cycle later): accept at cycle N, mem_req at N+1, rvalid at N+2, wb_valid at N+3.
- ld_ready=0 in all states except IDLE, so the unit holds at most one load in flight.
- Flush:
  - In IDLE: no effect. A load offered in the same cycle as flush is not accepted.
  - In REQ before grant: mem_req drops the next cycle and the state returns to IDLE.
  - In REQ with gnt in the same cycle as flush, or in WAIT: the unit waits for mem_rvalid (or timeout), discards the data, and raises no wb_valid and no ld_err.
  - In WB: wb_valid is suppressed.
  - A pending-flush flag is held until the unit returns to IDLE.
- Reset mid-transaction: returns immediately to IDLE. A later stray mem_rvalid seen in IDLE is ignored.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.

Test Plan:
- LW aligned: rs1=0x1000, imm=0x004, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF, rd=5 -> mem_addr=0x1004; wb_valid at accept+3 with wb_rd=5, wb_data=0xDEADBEEF.
- LB/LBU extraction: ea=0x2003, rdata=0x80112233 -> LB gives 0xFFFFFF80 and LBU gives 0x00000080; with ea=0x2002, LH on rdata=0x8001_1234 gives 0xFFFF8001 and LHU gives 0x00008001.
- Misaligned and negative offset: rs1=0x1002, imm=0xFFF (-1), LH -> ea=0x1001; ld_err=1, cause=1, ld_err_addr=0x1001; mem_req never asserts.
- Grant stall plus timeout (TIMEOUT_CYCLES=4): gnt withheld 3 cycles with mem_req and mem_addr held stable; then no rvalid -> ld_err with cause=2 after 4 WAIT cycles; ld_ready returns to 1.
- Flush in WAIT: flush pulsed one cycle after gnt, rvalid arrives 2 cycles later -> no wb_valid, no ld_err, unit returns to IDLE after rvalid. `LD_NOP accepted -> ld_ready back to 1 the next cycle with no mem_req.
- Async reset in REQ: rst_n pulled low mid-cycle -> mem_req=0 immediately; after release ld_ready=1, and an injected stray rvalid produces no wb_valid.

Source files
------------

// File: rtl/load_mem_unit.sv
// Load memory stage: EA add, mem req/gnt/rvalid handshake, byte/half align and extend, error pulses.
// Min latency accept->wb_valid is 3 cycles; ld_ready only in IDLE, so one load in flight at a time.
`ifndef LB
`define LB     3'b000
`define LH     3'b001
`define LW     3'b010
`define LBU    3'b100
`define LHU    3'b101
`define LD_NOP 3'b111
`endif

module load_mem_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] rs1_data,
  input  logic [11:0] imm,
  input  logic [4:0]  rd,
  input  logic [2:0]  load_control,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        ld_err,
  output logic [1:0]  ld_err_cause,
  output logic [31:0] ld_err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] ea_q;
  logic [4:0]  rd_q;
  logic [2:0]  ctrl_q;
  logic [7:0]  tmo_q;
  logic        flush_pend_q;
  logic        ld_ready_q, mem_req_q, wb_valid_q, ld_err_q;
  logic [31:0] mem_addr_q, wb_data_q, ld_err_addr_q;
  logic [4:0]  wb_rd_q;
  logic [1:0]  ld_err_cause_q;

  logic [31:0] ea_d;
  logic        is_nop_d;
  logic        misaligned_d;
  logic        accept;
  logic        discard;

  assign ea_d    = rs1_data + {{20{imm[11]}}, imm};
  assign accept  = ld_valid && ld_ready_q && !flush;
  assign discard = flush_pend_q || flush;

  // Unknown control encodings are treated like LD_NOP: no access, no error.
  always_comb begin
    is_nop_d     = 1'b0;
    misaligned_d = 1'b0;
    case (load_control)
      `LB, `LBU: misaligned_d = 1'b0;
      `LH, `LHU: misaligned_d = ea_d[0];
      `LW:       misaligned_d = (ea_d[1:0] != 2'b00);
      default:   is_nop_d     = 1'b1;
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] c,
                                          input logic [1:0] off);
    logic [31:0] bsh;
    logic [31:0] hsh;
    logic [31:0] res;
    bsh = w >> {off, 3'b000};
    hsh = w >> {off[1], 4'b0000};
    case (c)
      `LB:     res = {{24{bsh[7]}}, bsh[7:0]};
      `LBU:    res = {24'b0, bsh[7:0]};
      `LH:     res = {{16{hsh[15]}}, hsh[15:0]};
      `LHU:    res = {16'b0, hsh[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ea_q           <= '0;
      rd_q           <= '0;
      ctrl_q         <= '0;
      tmo_q          <= '0;
      flush_pend_q   <= 1'b0;
      ld_ready_q     <= 1'b1;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      ld_err_q       <= 1'b0;
      ld_err_cause_q <= '0;
      ld_err_addr_q  <= '0;
    end else begin
      wb_valid_q     <= 1'b0;
      ld_err_q       <= 1'b0;
      ld_err_cause_q <= 2'd0;
      case (state_q)
        S_IDLE: begin
          flush_pend_q <= 1'b0;
          if (accept) begin
            ea_q   <= ea_d;
            rd_q   <= rd;
            ctrl_q <= load_control;
            tmo_q  <= '0;
            if (is_nop_d) begin
              state_q <= S_IDLE;
            end else if (misaligned_d) begin
              ld_err_q       <= 1'b1;
              ld_err_cause_q <= 2'd1;
              ld_err_addr_q  <= ea_d;
            end else begin
              state_q    <= S_REQ;
              ld_ready_q <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {ea_d[31:2], 2'b00};
            end
          end
        end
        S_REQ: begin
          // A grant in the flush cycle commits the bus read; it must still be drained.
          if (mem_gnt) begin
            state_q   <= S_WAIT;
            mem_req_q <= 1'b0;
            tmo_q     <= '0;
            if (flush) flush_pend_q <= 1'b1;
          end else if (flush) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            ld_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_rvalid) begin
            if (discard) begin
              state_q    <= S_IDLE;
              ld_ready_q <= 1'b1;
            end else begin
              state_q    <= S_WB;
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= extract(mem_rdata, ctrl_q, ea_q[1:0]);
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q    <= S_IDLE;
            ld_ready_q <= 1'b1;
            if (!discard) begin
              ld_err_q       <= 1'b1;
              ld_err_cause_q <= 2'd2;
              ld_err_addr_q  <= ea_q;
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_WB: begin
          state_q    <= S_IDLE;
          ld_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= S_IDLE;
          ld_ready_q <= 1'b1;
          mem_req_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready     = ld_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  // A flush arriving during the WB cycle itself must still kill the writeback.
  assign wb_valid     = wb_valid_q && !flush;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign ld_err       = ld_err_q;
  assign ld_err_cause = ld_err_cause_q;
  assign ld_err_addr  = ld_err_addr_q;

endmodule

// File: tb/tb_load_mem_unit.sv
// Directed bench for load_mem_unit: vector table for extraction/misalignment plus hand sequences.
`ifndef LB
`define LB     3'b000
`define LH     3'b001
`define LW     3'b010
`define LBU    3'b100
`define LHU    3'b101
`define LD_NOP 3'b111
`endif

module tb_load_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_ready;
  logic [31:0] rs1_data;
  logic [11:0] imm;
  logic [4:0]  rd;
  logic [2:0]  load_control;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ld_err;
  logic [1:0]  ld_err_cause;
  logic [31:0] ld_err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  load_mem_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .rs1_data(rs1_data), .imm(imm), .rd(rd), .load_control(load_control),
    .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_err(ld_err), .ld_err_cause(ld_err_cause), .ld_err_addr(ld_err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  ctrl;
    logic [31:0] rdata;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] r, input logic [11:0] i, input logic [4:0] d,
                       input logic [2:0] c);
    ld_valid = 1'b1; rs1_data = r; imm = i; rd = d; load_control = c;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check({tag, " ld_ready before accept"}, {31'b0, ld_ready}, 32'd1);
    offer(v.rs1, v.imm, v.rd, v.ctrl);
    tick();
    ld_valid = 1'b0;
    if (v.mis) begin
      check({tag, " ld_err"}, {31'b0, ld_err}, 32'd1);
      check({tag, " ld_err_cause"}, {30'b0, ld_err_cause}, 32'd1);
      check({tag, " ld_err_addr"}, ld_err_addr, v.addr);
      check({tag, " mem_req on misalign"}, {31'b0, mem_req}, 32'd0);
      tick();
      check({tag, " ld_err one-shot"}, {31'b0, ld_err}, 32'd0);
      check({tag, " mem_req stays low"}, {31'b0, mem_req}, 32'd0);
    end else begin
      check({tag, " mem_req"}, {31'b0, mem_req}, 32'd1);
      check({tag, " mem_addr"}, mem_addr, v.addr);
      check({tag, " ld_ready busy"}, {31'b0, ld_ready}, 32'd0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check({tag, " mem_req dropped"}, {31'b0, mem_req}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      tick();
      mem_rvalid = 1'b0;
      check({tag, " wb_valid"}, {31'b0, wb_valid}, 32'd1);
      check({tag, " wb_rd"}, {27'b0, wb_rd}, {27'b0, v.rd});
      check({tag, " wb_data"}, wb_data, v.data);
      tick();
      check({tag, " wb_valid one-shot"}, {31'b0, wb_valid}, 32'd0);
    end
    check({tag, " ld_ready after"}, {31'b0, ld_ready}, 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_1000, 12'h004, 5'd5,  `LW,  32'hDEAD_BEEF, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_2000, 12'h003, 5'd1,  `LB,  32'h8011_2233, 1'b0, 32'h0000_2000, 32'hFFFF_FF80};
    vecs[2]  = '{32'h0000_2000, 12'h003, 5'd2,  `LBU, 32'h8011_2233, 1'b0, 32'h0000_2000, 32'h0000_0080};
    vecs[3]  = '{32'h0000_2000, 12'h002, 5'd3,  `LH,  32'h8001_1234, 1'b0, 32'h0000_2000, 32'hFFFF_8001};
    vecs[4]  = '{32'h0000_2000, 12'h002, 5'd4,  `LHU, 32'h8001_1234, 1'b0, 32'h0000_2000, 32'h0000_8001};
    vecs[5]  = '{32'h0000_1002, 12'hFFF, 5'd6,  `LH,  32'h0,         1'b1, 32'h0000_1001, 32'h0};
    vecs[6]  = '{32'h0000_1000, 12'h002, 5'd7,  `LW,  32'h0,         1'b1, 32'h0000_1002, 32'h0};
    vecs[7]  = '{32'h0000_0000, 12'h800, 5'd8,  `LB,  32'h0000_00F0, 1'b0, 32'hFFFF_F800, 32'hFFFF_FFF0};
    vecs[8]  = '{32'hFFFF_FFFE, 12'h004, 5'd9,  `LHU, 32'hABCD_0000, 1'b0, 32'h0000_0000, 32'h0000_ABCD};
    vecs[9]  = '{32'h0000_3000, 12'h001, 5'd10, `LBU, 32'h1122_3344, 1'b0, 32'h0000_3000, 32'h0000_0033};
    vecs[10] = '{32'h0000_3000, 12'h002, 5'd0,  `LB,  32'h007F_0000, 1'b0, 32'h0000_3000, 32'h0000_007F};
    vecs[11] = '{32'h0000_4000, 12'h000, 5'd31, `LH,  32'h1234_FFFE, 1'b0, 32'h0000_4000, 32'hFFFF_FFFE};

    rst_n = 1'b0; ld_valid = 1'b0; rs1_data = '0; imm = '0; rd = '0; load_control = `LD_NOP;
    flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick();
    tick();
    check("reset ld_ready", {31'b0, ld_ready}, 32'd1);
    check("reset mem_req", {31'b0, mem_req}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset ld_err", {31'b0, ld_err}, 32'd0);
    check("reset ld_err_addr", ld_err_addr, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Grant stall then bus timeout after 4 WAIT cycles
    offer(32'h0000_5000, 12'h008, 5'd3, `LW);
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall mem_req held", {31'b0, mem_req}, 32'd1);
      check("stall mem_addr held", mem_addr, 32'h0000_5008);
      tick();
    end
    check("stall mem_req before gnt", {31'b0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("timeout no early err", {31'b0, ld_err}, 32'd0);
      check("timeout busy", {31'b0, ld_ready}, 32'd0);
      tick();
    end
    check("timeout ld_err", {31'b0, ld_err}, 32'd1);
    check("timeout cause", {30'b0, ld_err_cause}, 32'd2);
    check("timeout addr", ld_err_addr, 32'h0000_5008);
    check("timeout ld_ready", {31'b0, ld_ready}, 32'd1);
    tick();
    check("timeout err one-shot", {31'b0, ld_err}, 32'd0);

    // Flush in WAIT, data returns later and is dropped
    offer(32'h0000_6000, 12'h000, 5'd12, `LW);
    tick();
    ld_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("flushwait busy", {31'b0, ld_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_rvalid = 1'b0;
    check("flushwait no wb", {31'b0, wb_valid}, 32'd0);
    check("flushwait no err", {31'b0, ld_err}, 32'd0);
    check("flushwait idle", {31'b0, ld_ready}, 32'd1);
    tick();
    check("flushwait still no wb", {31'b0, wb_valid}, 32'd0);

    // LD_NOP returns immediately without a bus access
    offer(32'h0000_7000, 12'h000, 5'd1, `LD_NOP);
    tick();
    ld_valid = 1'b0;
    check("nop ld_ready", {31'b0, ld_ready}, 32'd1);
    check("nop mem_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("nop no wb", {31'b0, wb_valid}, 32'd0);
    check("nop no err", {31'b0, ld_err}, 32'd0);

    // Flush in REQ before grant
    offer(32'h0000_8000, 12'h000, 5'd2, `LW);
    tick();
    ld_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flushreq mem_req", {31'b0, mem_req}, 32'd0);
    check("flushreq ld_ready", {31'b0, ld_ready}, 32'd1);

    // Load offered with flush in IDLE is not accepted
    offer(32'h0000_9000, 12'h000, 5'd2, `LW);
    flush = 1'b1;
    tick();
    ld_valid = 1'b0; flush = 1'b0;
    check("flushidle mem_req", {31'b0, mem_req}, 32'd0);
    check("flushidle ld_ready", {31'b0, ld_ready}, 32'd1);

    // Flush during the WB cycle suppresses wb_valid
    offer(32'h0000_A000, 12'h000, 5'd9, `LW);
    tick();
    ld_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    flush = 1'b1;
    #1;
    check("flushwb wb_valid", {31'b0, wb_valid}, 32'd0);
    tick();
    flush = 1'b0;
    check("flushwb ld_ready", {31'b0, ld_ready}, 32'd1);

    // Async reset while in REQ, then a stray rvalid in IDLE
    offer(32'h0000_B000, 12'h004, 5'd4, `LW);
    tick();
    ld_valid = 1'b0;
    check("arst mem_req before", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst mem_req immediate", {31'b0, mem_req}, 32'd0);
    check("arst ld_ready immediate", {31'b0, ld_ready}, 32'd1);
    #2 rst_n = 1'b1;
    tick();
    check("arst ld_ready after", {31'b0, ld_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick();
    mem_rvalid = 1'b0;
    check("stray rvalid no wb", {31'b0, wb_valid}, 32'd0);
    tick();
    check("stray rvalid no wb later", {31'b0, wb_valid}, 32'd0);
    check("stray rvalid no err", {31'b0, ld_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
